// File: rtl/fc3_data_sink_pkg.sv
// Shared definitions for the fc3 tensor capture sink: FSM encoding and readback latency.
package fc3_data_sink_pkg;

    typedef logic [0:0] fsm_state_t;

    localparam fsm_state_t CAPTURE = 1'b0;
    localparam fsm_state_t DONE    = 1'b1;

    localparam int RD_LATENCY = 2;

endpackage

// File: rtl/fc3_data_sink_ram.sv
// Simple dual-port RAM, one write and one read port, read data registered twice.
// Same-address read/write in one cycle returns the pre-write contents.
module fc3_data_sink_ram #(
    parameter int DEPTH      = 32,
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_pipe_en,
    output logic [WIDTH-1:0]      rd_data
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] s1_d, s1_q;
    logic [WIDTH-1:0] s2_d, s2_q;

    // Out-of-range read addresses alias onto the low index bits; their data is don't-care.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    always_comb begin
        s1_d = s1_q;
        s2_d = s2_q;
        if (rd_en) begin
            s1_d = mem[rd_addr[IDX_W-1:0]];
        end
        if (rd_pipe_en) begin
            s2_d = s1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign rd_data = s2_q;

endmodule

// File: rtl/fc3_data_sink.sv
// Captures one tensor of beats into RAM, then stops until clear; readback at any time,
// two-cycle latency, one read per cycle.
module fc3_data_sink
    import fc3_data_sink_pkg::*;
#(
    parameter int DATA_IN_TENSOR_SIZE_DIM_0 = 32,
    parameter int DATA_IN_TENSOR_SIZE_DIM_1 = 1,
    parameter int DATA_IN_PRECISION_0       = 16,
    parameter int DATA_IN_PRECISION_1       = 3,
    parameter int DATA_IN_PARALLELISM_DIM_0 = 1,
    parameter int DATA_IN_PARALLELISM_DIM_1 = 1,
    localparam int PAR        = DATA_IN_PARALLELISM_DIM_0 * DATA_IN_PARALLELISM_DIM_1,
    localparam int IN_DEPTH   = DATA_IN_TENSOR_SIZE_DIM_0 * DATA_IN_TENSOR_SIZE_DIM_1 / PAR,
    localparam int ADDR_WIDTH = $clog2(IN_DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_IN_PRECISION_0-1:0] data_in [PAR],
    input  logic                           data_in_valid,
    output logic                           data_in_ready,
    input  logic                           clear,
    input  logic                           rd_en,
    input  logic [ADDR_WIDTH-1:0]          rd_addr,
    output logic [DATA_IN_PRECISION_0-1:0] rd_data [PAR],
    output logic                           rd_data_valid,
    output logic [ADDR_WIDTH-1:0]          beat_count,
    output logic                           capture_done
);

    localparam int P     = DATA_IN_PRECISION_0;
    localparam int WIDTH = P * PAR;
    localparam logic [ADDR_WIDTH-1:0] LAST_BEAT = ADDR_WIDTH'(IN_DEPTH - 1);

    fsm_state_t              state_d, state_q;
    logic [ADDR_WIDTH-1:0]   beat_count_d, beat_count_q;
    logic [RD_LATENCY-1:0]   rd_vld_d, rd_vld_q;
    logic                    handshake;
    logic [WIDTH-1:0]        wr_word;
    logic [WIDTH-1:0]        rd_word;

    // clear wins over a coincident beat by dropping ready.
    always_comb begin
        data_in_ready = !rst && (state_q == CAPTURE) && !clear;
        handshake     = data_in_valid && data_in_ready;
        state_d       = state_q;
        beat_count_d  = beat_count_q;
        if (clear) begin
            state_d      = CAPTURE;
            beat_count_d = '0;
        end else if (handshake) begin
            beat_count_d = beat_count_q + ADDR_WIDTH'(1);
            if (beat_count_q == LAST_BEAT) begin
                state_d = DONE;
            end
        end
        rd_vld_d = {rd_vld_q[RD_LATENCY-2:0], rd_en};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= CAPTURE;
            beat_count_q <= '0;
            rd_vld_q     <= '0;
        end else begin
            state_q      <= state_d;
            beat_count_q <= beat_count_d;
            rd_vld_q     <= rd_vld_d;
        end
    end

    always_comb begin
        wr_word = '0;
        for (int j = 0; j < PAR; j++) begin
            wr_word[P*j +: P] = data_in[j];
            rd_data[j]        = rd_word[P*j +: P];
        end
    end

    fc3_data_sink_ram #(
        .DEPTH      (IN_DEPTH),
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (handshake),
        .wr_addr    (beat_count_q),
        .wr_data    (wr_word),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_pipe_en (rd_vld_q[0]),
        .rd_data    (rd_word)
    );

    assign rd_data_valid = rd_vld_q[RD_LATENCY-1];
    assign beat_count    = beat_count_q;
    assign capture_done  = (state_q == DONE);

endmodule

// File: tb/tb_fc3_data_sink.sv
// Directed bench for fc3_data_sink (4 elements per beat, 8 beats); reads checked by a scoreboard monitor.
module tb_fc3_data_sink;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data_in [4];
    logic        data_in_valid = 1'b0;
    logic        data_in_ready;
    logic        clear = 1'b0;
    logic        rd_en = 1'b0;
    logic [3:0]  rd_addr = '0;
    logic [15:0] rd_data [4];
    logic        rd_data_valid;
    logic [3:0]  beat_count;
    logic        capture_done;

    fc3_data_sink #(
        .DATA_IN_TENSOR_SIZE_DIM_0 (32),
        .DATA_IN_TENSOR_SIZE_DIM_1 (1),
        .DATA_IN_PRECISION_0       (16),
        .DATA_IN_PRECISION_1       (3),
        .DATA_IN_PARALLELISM_DIM_0 (4),
        .DATA_IN_PARALLELISM_DIM_1 (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .clear         (clear),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_data_valid (rd_data_valid),
        .beat_count    (beat_count),
        .capture_done  (capture_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] dat;
        int          due;
    } rd_exp_t;

    rd_exp_t     rq [$];
    logic [63:0] exp_mem [8];
    int          exp_count = 0;
    bit          exp_done  = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc_n = 0;
    logic [63:0] last_rd = '0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    function automatic logic [63:0] mk(input int base);
        return {16'(base + 3), 16'(base + 2), 16'(base + 1), 16'(base)};
    endfunction

    function automatic logic [63:0] pack_rd();
        logic [63:0] w;
        for (int j = 0; j < 4; j++) w[16*j +: 16] = rd_data[j];
        return w;
    endfunction

    // One clock of stimulus; status checked mid-cycle against the bench model, then model advanced.
    task automatic cyc(input bit v, input logic [63:0] dw, input bit clr, input bit re, input int ra);
        bit      exp_rdy;
        rd_exp_t e;
        @(posedge clk); #1;
        data_in_valid = v;
        for (int j = 0; j < 4; j++) data_in[j] = dw[16*j +: 16];
        clear   = clr;
        rd_en   = re;
        rd_addr = 4'(ra);
        @(negedge clk);
        exp_rdy = !exp_done && !clr;
        chk("ready", data_in_ready, exp_rdy);
        chk("beat_count", beat_count, exp_count);
        chk("capture_done", capture_done, exp_done);
        if (re) begin
            e.dat = exp_mem[ra];
            e.due = cyc_n + 2;
            rq.push_back(e);
        end
        if (clr) begin
            exp_count = 0;
            exp_done  = 1'b0;
        end else if (v && exp_rdy) begin
            exp_mem[exp_count] = dw;
            exp_count++;
            if (exp_count == 8) exp_done = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 64'h0, 1'b0, 1'b0, 0);
    endtask

    task automatic read_all();
        for (int a = 0; a < 8; a++) cyc(1'b0, 64'h0, 1'b0, 1'b1, a);
        idle(3);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        data_in_valid = 1'b0;
        clear = 1'b0;
        rd_en = 1'b0;
        @(negedge clk);
        chk("rst_ready_low", data_in_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        rq.delete();
        exp_count = 0;
        exp_done  = 1'b0;
        @(negedge clk);
        chk("rst_ready_high", data_in_ready, 1'b1);
        chk("rst_beat_count", beat_count, 4'd0);
        chk("rst_capture_done", capture_done, 1'b0);
        chk("rst_rd_data_valid", rd_data_valid, 1'b0);
        chk("rst_rd_data", pack_rd(), 64'h0);
    endtask

    // Read scoreboard: data, exact latency, hold when idle, no spurious or missing results.
    always @(negedge clk) begin
        rd_exp_t     e;
        logic [63:0] cur;
        if (rst) begin
            last_rd = '0;
        end else begin
            cur = pack_rd();
            if (rd_data_valid) begin
                if (rq.size() == 0) begin
                    chk("rd_unexpected", rd_data_valid, 1'b0);
                end else begin
                    e = rq.pop_front();
                    chk("rd_data", cur, e.dat);
                    chk("rd_latency", cyc_n, e.due);
                end
            end else begin
                chk("rd_hold", cur, last_rd);
                if (rq.size() > 0 && rq[0].due <= cyc_n) begin
                    chk("rd_missing", rd_data_valid, 1'b1);
                    void'(rq.pop_front());
                end
            end
            last_rd = cur;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [15:0] gap_pat;
        for (int j = 0; j < 4; j++) data_in[j] = '0;
        for (int k = 0; k < 8; k++) exp_mem[k] = 'x;
        do_reset();

        // Full-rate stream, element j of beat k = 4k+j; then a beat while DONE is ignored.
        for (int k = 0; k < 8; k++) cyc(1'b1, mk(4 * k), 1'b0, 1'b0, 0);
        cyc(1'b1, 64'hBEEF_BEEF_BEEF_BEEF, 1'b0, 1'b0, 0);
        idle(1);
        read_all();

        // clear in DONE together with a beat: no write, re-armed, old data intact.
        cyc(1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 1'b0, 0);
        idle(1);
        read_all();

        // Gapped stream; idle cycles carry junk data that must not land.
        gap_pat = 16'b1011_0010_1101_0110;
        for (int i = 0; i < 40 && exp_count < 8; i++) begin
            if (gap_pat[i % 16]) cyc(1'b1, mk(16'h1000 + 4 * exp_count), 1'b0, 1'b0, 0);
            else                 cyc(1'b0, 64'hDEAD_DEAD_DEAD_DEAD, 1'b0, 1'b0, 0);
        end
        idle(1);
        read_all();

        // Recapture: write and read address 2 in the same cycle returns the old word.
        cyc(1'b0, 64'h0, 1'b1, 1'b0, 0);
        cyc(1'b1, mk(16'h2000), 1'b0, 1'b0, 0);
        cyc(1'b1, mk(16'h2004), 1'b0, 1'b0, 0);
        cyc(1'b1, mk(16'h2008), 1'b0, 1'b1, 2);
        cyc(1'b0, 64'h0, 1'b0, 1'b1, 2);
        idle(3);

        // Reset after beat 3 discards progress; a fresh capture then completes.
        cyc(1'b0, 64'h0, 1'b1, 1'b0, 0);
        for (int k = 0; k < 4; k++) cyc(1'b1, mk(16'h2800 + 4 * k), 1'b0, 1'b0, 0);
        do_reset();
        for (int k = 0; k < 8; k++) cyc(1'b1, mk(16'h3000 + 4 * k), 1'b0, 1'b0, 0);
        idle(1);
        read_all();

        chk("rd_queue_drained", 64'(rq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
